// File: rtl/match_sched.sv
// match_sched: sequences a shared difference counter over all templates and reports the best-matching class.
module match_sched #(
  parameter int MODN = 30,
  parameter int CLAS = 5,
  parameter int MODI = 6,
  parameter int ADDW = 14,
  parameter logic [ADDW-1:0] TH = 2000,
  parameter int WDOG = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            tmpl_req,
  output logic [4:0]      tmpl_idx,
  input  logic            cnt_vld,
  input  logic [ADDW-1:0] cnt,
  output logic            busy,
  output logic [2:0]      res,
  output logic            res_vld,
  input  logic            res_rdy
);
  localparam int WW = $clog2(WDOG + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DECIDE, DONE} state_t;
  state_t state, state_n;
  logic [4:0]      idx;
  logic [2:0]      cls, mod, min_cls;
  logic [ADDW-1:0] min;
  logic [WW-1:0]   wd;
  logic            last, expire;
  assign last     = idx == 5'(MODN - 1);
  assign expire   = wd == WW'(WDOG - 1);
  assign busy     = state != IDLE;
  assign tmpl_req = state == ISSUE;
  assign tmpl_idx = idx;
  assign res_vld  = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else
      unique case (state)
        IDLE:    state_n = start ? ISSUE : IDLE;
        ISSUE:   state_n = WAIT;
        WAIT:    state_n = cnt_vld ? (last ? DECIDE : ISSUE) : (expire ? DONE : WAIT);
        DECIDE:  state_n = DONE;
        DONE:    state_n = res_rdy ? IDLE : DONE;
        default: state_n = IDLE;
      endcase
  end
  // Abort freezes every datapath register; res survives until the next decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      cls     <= '0;
      mod     <= '0;
      min     <= '1;
      min_cls <= '0;
      wd      <= '0;
      res     <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE:
          if (start) begin
            idx     <= '0;
            cls     <= '0;
            mod     <= '0;
            min     <= '1;
            min_cls <= '0;
          end
        ISSUE: wd <= '0;
        WAIT:
          if (cnt_vld) begin
            if (cnt < min) begin
              min     <= cnt;
              min_cls <= cls + 3'd1;
            end
            if (!last) begin
              idx <= idx + 5'd1;
              mod <= (mod == 3'(MODI - 1)) ? 3'd0 : mod + 3'd1;
              cls <= (mod == 3'(MODI - 1)) ? cls + 3'd1 : cls;
            end
          end else begin
            wd <= wd + WW'(1);
            if (expire) res <= 3'd0;
          end
        DECIDE: res <= (min < TH) ? min_cls : 3'd7;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_match_sched.sv
// tb_match_sched: randomized and directed scans checked against a per-frame arithmetic model.
module tb_match_sched;
  localparam int MODN = 30, MODI = 6, TH = 2000, WDOG = 255;
  logic clk = 0, rst = 1, start = 0, abort = 0, cnt_vld = 0, res_rdy = 0;
  logic [13:0] cnt = 0;
  logic tmpl_req, busy, res_vld;
  logic [4:0] tmpl_idx;
  logic [2:0] res;
  int counts[MODN], delays[MODN];
  int pending = -1, cd = 0, n_chk = 0, n_fail = 0;
  match_sched dut (.clk(clk), .rst(rst), .start(start), .abort(abort), .tmpl_req(tmpl_req),
    .tmpl_idx(tmpl_idx), .cnt_vld(cnt_vld), .cnt(cnt), .busy(busy), .res(res),
    .res_vld(res_vld), .res_rdy(res_rdy));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic respond();
    cnt_vld = 0;
    if (pending >= 0) begin
      if (cd == 0) begin
        cnt_vld = 1;
        cnt = 14'(counts[pending]);
        pending = -1;
      end else cd--;
    end
  endtask
  task automatic fill(input int base);
    for (int i = 0; i < MODN; i++) begin
      counts[i] = base;
      delays[i] = 0;
    end
  endtask
  function automatic void model(output int r, output int lat);
    int m = 16383, b = 0;
    lat = 0;
    for (int i = 0; i < MODN; i++) begin
      if (delays[i] >= WDOG) begin
        lat += WDOG + 2;
        r = 0;
        return;
      end
      lat += 2 + delays[i];
      if (counts[i] < m) begin
        m = counts[i];
        b = i;
      end
    end
    lat += 2;
    r = (m < TH) ? b / MODI + 1 : 7;
  endfunction
  task automatic scan(input string tag, input int hold);
    int nreq = 0, lat = -1, er, el, r;
    model(er, el);
    start = 1;
    tick();
    for (int c = 1; c < 20000; c++) begin
      start = (c == 7);
      respond();
      if (tmpl_req) begin
        chk({tag, "_idx"}, int'(tmpl_idx), nreq);
        nreq++;
        pending = int'(tmpl_idx);
        cd = delays[pending];
      end
      if (res_vld) begin
        lat = c;
        break;
      end
      tick();
    end
    start = 0;
    cnt_vld = 0;
    pending = -1;
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, int'(res), er);
    r = int'(res);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_vld"}, int'(res_vld), 1);
      chk({tag, "_hold_res"}, int'(res), r);
      chk({tag, "_hold_req"}, int'(tmpl_req), 0);
    end
    res_rdy = 1;
    tick();
    res_rdy = 0;
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_vld_after"}, int'(res_vld), 0);
  endtask
  initial begin
    int prev;
    bit seen;
    tick();
    tick();
    rst = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(res_vld), 0);
    chk("rst_req", int'(tmpl_req), 0);
    chk("rst_res", int'(res), 0);
    fill(3000); counts[13] = 500;
    scan("single", 2);
    fill(3000); counts[7] = 100; counts[20] = 100;
    scan("tie", 0);
    fill(3000); counts[5] = 2000;
    scan("at_th", 0);
    fill(3000); counts[29] = 1999;
    scan("last_tmpl", 20);
    fill(3000); counts[2] = 10; delays[4] = 1000;
    scan("timeout", 5);
    fill(3000); counts[3] = 50;
    prev = int'(res);
    start = 1;
    tick();
    start = 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      respond();
      if (tmpl_req) begin
        pending = int'(tmpl_idx);
        cd = 0;
        seen = (tmpl_idx == 5'd10);
      end
      if (!seen) tick();
    end
    chk("abort_reached", int'(seen), 1);
    abort = 1;
    cnt_vld = 1;
    tick();
    abort = 0;
    cnt_vld = 0;
    pending = -1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_vld", int'(res_vld), 0);
    chk("abort_req", int'(tmpl_req), 0);
    chk("abort_res", int'(res), prev);
    fill(3000); counts[25] = 700;
    scan("post_abort", 0);
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < MODN; i++) begin
        counts[i] = $urandom_range(1700, 4000);
        delays[i] = $urandom_range(0, 3);
      end
      if (t % 4 == 1) counts[$urandom_range(0, MODN - 1)] = TH;
      if (t % 4 == 2) counts[$urandom_range(0, MODN - 1)] = TH - 1;
      if (t == 5) delays[$urandom_range(0, MODN - 1)] = WDOG - 1;
      scan("rand", $urandom_range(0, 3));
    end
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    rst = 1;
    abort = 1;
    tick();
    rst = 0;
    abort = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_res", int'(res), 0);
    chk("midrst_req", int'(tmpl_req), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
